// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the single-bus CPU control path: the ALU operation
// sequencer state type, default datapath widths, and the ALU opcode
// constants that the sequencer, the ALU and the instruction decoder all
// agree on.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Default datapath geometry.
    localparam int W_DEFAULT     = 16;
    localparam int NREGS_DEFAULT = 8;
    localparam int REGW_DEFAULT  = $clog2(NREGS_DEFAULT);
    localparam int OPW_DEFAULT   = 4;

    // ALU opcodes. Code 0 is a no-op; the sequencer presents 0 to the ALU
    // whenever no operation is being evaluated.
    localparam logic [OPW_DEFAULT-1:0] ALU_NOP   = 4'h0;
    localparam logic [OPW_DEFAULT-1:0] ALU_ADD   = 4'h1;
    localparam logic [OPW_DEFAULT-1:0] ALU_SUB   = 4'h2;
    localparam logic [OPW_DEFAULT-1:0] ALU_AND   = 4'h3;
    localparam logic [OPW_DEFAULT-1:0] ALU_OR    = 4'h4;
    localparam logic [OPW_DEFAULT-1:0] ALU_XOR   = 4'h5;
    localparam logic [OPW_DEFAULT-1:0] ALU_SLL   = 4'h6;
    localparam logic [OPW_DEFAULT-1:0] ALU_SRL   = 4'h7;
    localparam logic [OPW_DEFAULT-1:0] ALU_PASSB = 4'h8;

    // Sequencer bus schedule: idle, first operand to Y, second operand
    // through the ALU into Z, Z written back to the destination register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRC1 = 2'd1,
        SRC2 = 2'd2,
        WB   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
// Binary index to one-hot decoder with enable. Indices at or beyond OUT_W
// decode to all zeros.
//
// Ports:
//   en      in   1       decoder enable; output is all zeros when low
//   idx     in   IN_W    binary index
//   onehot  out  OUT_W   one-hot result (bit idx set when en)
// ---------------------------------------------------------------------------
module onehot_decoder #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1 << IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] onehot
);

    // NOTE: combinational outputs get a default before any conditional
    // assignment so no path leaves them unassigned (which would infer a latch).
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (en && (idx == IN_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Control sequencer for the single-bus datapath. Runs one register-register
// or register-immediate ALU operation as a fixed three-cycle bus schedule:
//   SRC1: rs1 onto the bus, latched into Y
//   SRC2: rs2 (or the immediate) onto the bus, ALU result latched into Z
//   WB  : Z onto the bus, latched into rd
// Exactly one source drives the shared bus in any cycle. A new request can
// be accepted in WB, giving one operation every three cycles.
//
// Ports:
//   clk          in   1      clock
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request; accepted at an edge where start && ready
//   op           in   OPW    ALU opcode (sampled on accept)
//   rs1/rs2/rd   in   REGW   source / destination indices (sampled on accept)
//   imm_sel      in   1      1: second operand is imm instead of rs2
//   imm          in   W      immediate (sampled on accept)
//   ready        out  1      request can be accepted this cycle
//   done         out  1      pulse during the write-back cycle
//   reg_out_en   out  1      register file drives the bus
//   reg_out_sel  out  REGW   register driving the bus (0 when not driving)
//   reg_in_en    out  NREGS  one-hot register latch enable (WB only)
//   imm_out_en   out  1      immediate driver enables the bus
//   imm_bus      out  W      latched immediate value
//   Y_in         out  1      Y latch strobe
//   alu_op       out  OPW    opcode presented to the ALU (0 outside SRC2)
//   Z_in         out  1      Z latch strobe
//   Z_out        out  1      Z drives the bus
//   op_count     out  16     completed operations, wraps
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int REGW  = $clog2(NREGS),
    parameter int OPW   = OPW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [REGW-1:0]  rs1,
    input  logic [REGW-1:0]  rs2,
    input  logic [REGW-1:0]  rd,
    input  logic             imm_sel,
    input  logic [W-1:0]     imm,
    output logic             ready,
    output logic             done,
    output logic             reg_out_en,
    output logic [REGW-1:0]  reg_out_sel,
    output logic [NREGS-1:0] reg_in_en,
    output logic             imm_out_en,
    output logic [W-1:0]     imm_bus,
    output logic             Y_in,
    output logic [OPW-1:0]   alu_op,
    output logic             Z_in,
    output logic             Z_out,
    output logic [15:0]      op_count
);

    seq_state_t      state;
    seq_state_t      state_next;
    logic            accept;
    logic            writeback;

    // Operand latches, captured when a request is accepted.
    logic [OPW-1:0]  op_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic            imm_sel_q;
    logic [W-1:0]    imm_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. Strobes depend only on the state register
    // and the operand latches; ready depends on the state alone.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        done        = 1'b0;
        writeback   = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = '0;
        imm_out_en  = 1'b0;
        Y_in        = 1'b0;
        alu_op      = '0;
        Z_in        = 1'b0;
        Z_out       = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = SRC1;
            end
            SRC1: begin
                reg_out_en  = 1'b1;
                reg_out_sel = rs1_q;
                Y_in        = 1'b1;
                state_next  = SRC2;
            end
            SRC2: begin
                if (imm_sel_q) begin
                    imm_out_en = 1'b1;
                end else begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = rs2_q;
                end
                alu_op     = op_q;
                Z_in       = 1'b1;
                state_next = WB;
            end
            WB: begin
                // Z_in is low here, so Z drives the result it captured in SRC2.
                Z_out      = 1'b1;
                writeback  = 1'b1;
                done       = 1'b1;
                ready      = 1'b1;
                state_next = start ? SRC1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept  = start && ready;
    assign imm_bus = imm_q;

    // ------------------------------------------------------------------
    // Operand latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
        end else if (accept) begin
            op_q      <= op;
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            rd_q      <= rd;
            imm_sel_q <= imm_sel;
            imm_q     <= imm;
        end
    end

    // ------------------------------------------------------------------
    // Completed-operation counter; an operation completes at the edge
    // ending its WB cycle. Wraps naturally at 16 bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (state == WB) begin
            op_count <= op_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Destination latch enable, asserted only during write-back.
    // ------------------------------------------------------------------
    onehot_decoder #(
        .IN_W  (REGW),
        .OUT_W (NREGS)
    ) u_rd_decoder (
        .en     (writeback),
        .idx    (rd_q),
        .onehot (reg_in_en)
    );

endmodule
